pwm_dac: RTL and testbench

- Downstream stage of the Exp3 top level: turns the 8-bit sample word `out` into a 1-bit PWM stream for an RC low-pass filter/LED on a board pin.
- A sample is captured only at PWM period boundaries, so duty never changes mid-period.
- Includes a clock prescaler, an enable, and a period-boundary strobe the producer can use to pace its updates.

---
 rtl/dld_pkg.sv | 20 ++
 rtl/pwm_dac_clk_prescaler.sv | 28 ++
 rtl/pwm_dac.sv | 68 ++++++
 tb/tb_pwm_dac.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dld_pkg.sv
// Shared definitions for the Exp3 datapath stages.
package dld_pkg;

  localparam int DATA_W_DEF = 8;

  // PWM counter terminal value: period is pwm_top(w)+1 counts, so a full-scale
  // duty word (2^w-1) stays high for the whole period.
  function automatic int pwm_top(input int w);
    return (1 << w) - 2;
  endfunction

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pwm_dac_clk_prescaler.sv
// Divides clk into a one-cycle strobe every PRESCALE cycles while enabled.
module clk_prescaler
  import dld_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre_cnt;

  assign tick = en && (r_pre_cnt == LAST);

  // Prescale counter: held at 0 while idle or on clr, wraps after LAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_pre_cnt <= '0;
    else if (!en || clr || tick) r_pre_cnt <= '0;
    else                        r_pre_cnt <= r_pre_cnt + PW'(1);
  end

endmodule

// File: rtl/pwm_dac.sv
// 8-bit (default) sample to 1-bit PWM; duty latched only at period boundaries.
module pwm_dac
  import dld_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] sample_in,
  output logic              pwm_out,
  output logic              period_tick,
  output logic [DATA_W-1:0] duty_q
);

  localparam logic [DATA_W-1:0] TOP = DATA_W'(pwm_top(DATA_W));

  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_duty;
  logic              r_en_q;
  logic              r_tick;

  logic w_tick;
  logic w_load;

  // A load starts a new period: either the natural wrap or the first enabled
  // edge after idle/reset. en low overrides both.
  assign w_load = en && ((w_tick && (r_cnt == TOP)) || !r_en_q);

  clk_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (w_load),
    .tick (w_tick)
  );

  // Period counter, duty latch and boundary strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_en_q <= 1'b0;
      r_tick <= 1'b0;
    end else if (!en) begin
      r_cnt  <= '0;
      r_en_q <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_en_q <= 1'b1;
      if (w_load) begin
        r_duty <= sample_in;
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_tick <= 1'b0;
        if (w_tick) r_cnt <= r_cnt + DATA_W'(1);
      end
    end
  end

  // Output decoded from registers only so it is glitch-free at the pin.
  assign pwm_out     = r_en_q && (r_cnt < r_duty);
  assign period_tick = r_tick;
  assign duty_q      = r_duty;

endmodule

// File: tb/tb_pwm_dac.sv
module tb_pwm_dac;

  localparam int PER = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en1 = 1'b0, en4 = 1'b0;
  logic [7:0] s1 = 8'h00, s4 = 8'h00;
  logic       pwm1, pwm4, tk1, tk4;
  logic [7:0] dq1, dq4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwm_dac #(.DATA_W(8), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .sample_in(s1),
    .pwm_out(pwm1), .period_tick(tk1), .duty_q(dq1));

  pwm_dac #(.DATA_W(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .sample_in(s4),
    .pwm_out(pwm4), .period_tick(tk4), .duty_q(dq4));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks each DUT as "clk cycles since period start" plus the latched duty;
  // output is high for the first duty*PRESCALE cycles of the period.
  int mP[2] = '{1, 4};
  bit m_act[2];
  int m_ph[2];
  int m_duty[2];
  bit m_tick[2];

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      logic e;
      int   s;
      e = (k == 0) ? en1 : en4;
      s = (k == 0) ? int'(s1) : int'(s4);
      if (!rst) begin
        m_act[k] = 0; m_ph[k] = 0; m_duty[k] = 0; m_tick[k] = 0;
      end else if (!e) begin
        m_act[k] = 0; m_ph[k] = 0; m_tick[k] = 0;
      end else if (!m_act[k] || m_ph[k] == PER * mP[k] - 1) begin
        m_act[k] = 1; m_ph[k] = 0; m_duty[k] = s; m_tick[k] = 1;
      end else begin
        m_ph[k]++; m_tick[k] = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int ep;
      ep = (m_act[k] && (m_ph[k] < m_duty[k] * mP[k])) ? 1 : 0;
      chk(k == 0 ? "m1_pwm"  : "m4_pwm",  int'(k == 0 ? pwm1 : pwm4), ep);
      chk(k == 0 ? "m1_tick" : "m4_tick", int'(k == 0 ? tk1 : tk4), int'(m_tick[k]));
      chk(k == 0 ? "m1_duty" : "m4_duty", int'(k == 0 ? dq1 : dq4), m_duty[k]);
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic pw(input int k);
    return (k == 0) ? pwm1 : pwm4;
  endfunction

  function automatic logic tk(input int k);
    return (k == 0) ? tk1 : tk4;
  endfunction

  task automatic sync_tick(input int k);
    int n;
    n = 0;
    while (!tk(k) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("sync_tick", int'(tk(k)), 1);
  endtask

  // Starts on a tick cycle; counts cycles and high cycles until the next tick.
  // Optionally changes sample_in at cycle chg_at of the period.
  task automatic measure(input int k, input int chg_at, input int chg_val,
                         output int len, output int highs);
    len = 0;
    highs = 0;
    do begin
      if (pw(k)) highs++;
      len++;
      if (len == chg_at) begin
        if (k == 0) s1 = 8'(chg_val);
        else        s4 = 8'(chg_val);
      end
      @(negedge clk);
    end while (!tk(k) && len < 5000);
  endtask

  int len, hi;

  initial begin
    // Reset held with inputs active
    en1 = 1'b1; s1 = 8'hAA; s4 = 8'd3;
    repeat (3) begin
      @(negedge clk);
      chk("rst_pwm", int'(pwm1), 0);
      chk("rst_tick", int'(tk1), 0);
      chk("rst_duty", int'(dq1), 0);
    end
    #1 rst = 1'b1; s1 = 8'd128;

    // Basic duty 128
    @(negedge clk);
    sync_tick(0);
    repeat (3) begin
      measure(0, -1, 0, len, hi);
      chk("b128_len", len, 255);
      chk("b128_hi", hi, 128);
    end

    // Extremes
    s1 = 8'd0;
    measure(0, -1, 0, len, hi);
    chk("x_prev_hi", hi, 128);
    repeat (2) begin
      measure(0, -1, 0, len, hi);
      chk("x0_hi", hi, 0);
      chk("x0_duty", int'(dq1), 0);
    end
    s1 = 8'd255;
    measure(0, -1, 0, len, hi);
    chk("x0b_hi", hi, 0);
    chk("x255_first", int'(pwm1), 1);
    repeat (2) begin
      measure(0, -1, 0, len, hi);
      chk("x255_hi", hi, 255);
      chk("x255_duty", int'(dq1), 255);
    end

    // Mid-period change
    s1 = 8'd64;
    measure(0, -1, 0, len, hi);
    chk("mid_duty_pre", int'(dq1), 64);
    measure(0, 10, 200, len, hi);
    chk("mid_hi64", hi, 64);
    chk("mid_duty_post", int'(dq1), 200);
    measure(0, -1, 0, len, hi);
    chk("mid_hi200", hi, 200);
    chk("mid_len", len, 255);

    // Async reset at cycle 100 of a duty-200 period
    repeat (100) @(negedge clk);
    chk("ar_pre_pwm", int'(pwm1), 1);
    #1 rst = 1'b0;
    #1;
    chk("ar_pwm", int'(pwm1), 0);
    chk("ar_tick", int'(tk1), 0);
    chk("ar_duty", int'(dq1), 0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ar_tick_after", int'(tk1), 1);
    measure(0, -1, 0, len, hi);
    chk("ar_hi", hi, 200);
    chk("ar_len", len, 255);

    // Prescaler 4 with enable drop/raise
    en4 = 1'b1;
    @(negedge clk);
    chk("p4_first_tick", int'(tk4), 1);
    measure(1, -1, 0, len, hi);
    chk("p4_len", len, 1020);
    chk("p4_hi", hi, 12);
    repeat (500) @(negedge clk);
    en4 = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("p4_off_pwm", int'(pwm4), 0);
      chk("p4_off_tick", int'(tk4), 0);
    end
    chk("p4_off_duty", int'(dq4), 3);
    en4 = 1'b1;
    @(negedge clk);
    chk("p4_rise_tick", int'(tk4), 1);
    measure(1, -1, 0, len, hi);
    chk("p4_len2", len, 1020);
    chk("p4_hi2", hi, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
